// File: rtl/pair_deser_pkg.sv
// ---------------------------------------------------------------------------
// pair_deser_pkg
// Shared types and helpers for the pair deserializer.
//   state_t   : capture FSM states (FILL1, FILL2, HOLD)
//   idx_width : width of the bit-index register for a given word width
// ---------------------------------------------------------------------------
package pair_deser_pkg;

    typedef enum logic [1:0] {
        FILL1 = 2'd0,
        FILL2 = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // A 1-bit word still needs a 1-bit index register.
    function automatic int idx_width(input int bits);
        return (bits <= 1) ? 1 : $clog2(bits);
    endfunction

endpackage

// File: rtl/bit_capture.sv
// ---------------------------------------------------------------------------
// bit_capture
// BITS-wide word register written one bit at a time.
//   i_clk  : rising-edge clock
//   i_rst  : synchronous, active-high reset (word -> 0)
//   i_we   : write enable for this cycle
//   i_idx  : bit position to write (0..BITS-1)
//   i_bit  : value written to word[i_idx]
//   o_word : registered word; unwritten bits keep their previous value
// ---------------------------------------------------------------------------
module bit_capture
    import pair_deser_pkg::*;
#(
    parameter int BITS  = 3,
    parameter int IDX_W = idx_width(BITS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_bit,
    output logic [BITS-1:0]  o_word
);

    logic [BITS-1:0] word_q;

    // Explicit decode instead of word_q[i_idx]: positions at or above BITS
    // simply match nothing, so no out-of-range index is ever formed.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_q <= '0;
        end else begin
            for (int i = 0; i < BITS; i++) begin
                if (i_we && (i_idx == IDX_W'(i))) begin
                    word_q[i] <= i_bit;
                end
            end
        end
    end

    assign o_word = word_q;

endmodule

// File: rtl/pair_deserializer.sv
// ---------------------------------------------------------------------------
// pair_deserializer
// Captures an LSB-first serial stream into two BITS-wide words and presents
// the pair with a valid/ready handshake, back-pressuring the source while
// the pair is held.
//   i_clk       : rising-edge clock
//   i_rst       : synchronous, active-high reset
//   i_clear     : synchronous flush of any partial capture or held pair
//   i_bit       : serial data bit
//   i_bit_valid : i_bit is valid this cycle
//   o_bit_ready : a serial bit can be accepted this cycle
//   o_word1     : first captured word (registered)
//   o_word2     : second captured word (registered)
//   o_valid     : o_word1/o_word2 hold a complete pair
//   i_ready     : downstream accepts the pair
// ---------------------------------------------------------------------------
module pair_deserializer
    import pair_deser_pkg::*;
#(
    parameter int BITS = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_bit,
    input  logic            i_bit_valid,
    output logic            o_bit_ready,
    output logic [BITS-1:0] o_word1,
    output logic [BITS-1:0] o_word2,
    output logic            o_valid,
    input  logic            i_ready
);

    localparam int               IDX_W    = idx_width(BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             we1, we2;
    logic             accept;

    // Ready depends only on state; it is also forced low while reset is held
    // so no bit appears accepted before the state register is initialised.
    assign o_bit_ready = (state_q != HOLD) && !i_rst;
    assign accept      = i_bit_valid && o_bit_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FILL1;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        we1     = 1'b0;
        we2     = 1'b0;

        unique case (state_q)
            FILL1: begin
                if (accept) begin
                    we1 = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = FILL2;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FILL2: begin
                if (accept) begin
                    we2 = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    state_d = FILL1;
                end
            end
            default: begin
                state_d = FILL1;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        // Flush overrides any accept or handshake; the words keep their
        // contents, only the capture position and valid are dropped.
        if (i_clear) begin
            state_d = FILL1;
            idx_d   = '0;
            valid_d = 1'b0;
            we1     = 1'b0;
            we2     = 1'b0;
        end
    end

    bit_capture #(.BITS(BITS), .IDX_W(IDX_W)) u_word1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (we1),
        .i_idx  (idx_q),
        .i_bit  (i_bit),
        .o_word (o_word1)
    );

    bit_capture #(.BITS(BITS), .IDX_W(IDX_W)) u_word2 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (we2),
        .i_idx  (idx_q),
        .i_bit  (i_bit),
        .o_word (o_word2)
    );

    assign o_valid = valid_q;

endmodule

// File: tb/tb_pair_deserializer.sv
// ---------------------------------------------------------------------------
// tb_pair_deserializer
// Directed bench for pair_deserializer: a BITS=3 instance and a BITS=1
// instance sharing one clock. Inputs change 1 ns after the rising edge and
// outputs are compared at that same point, i.e. after the edge settles.
// ---------------------------------------------------------------------------
module tb_pair_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // BITS=3 instance
    logic       rst, clr, bv, b, rdy;
    logic       br, v;
    logic [2:0] w1, w2;

    // BITS=1 instance
    logic       rst1, clr1, bv1, b1, rdy1;
    logic       br1, v1;
    logic [0:0] w1_1, w2_1;

    int checks = 0;
    int errors = 0;

    pair_deserializer #(.BITS(3)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clear     (clr),
        .i_bit       (b),
        .i_bit_valid (bv),
        .o_bit_ready (br),
        .o_word1     (w1),
        .o_word2     (w2),
        .o_valid     (v),
        .i_ready     (rdy)
    );

    pair_deserializer #(.BITS(1)) dut1 (
        .i_clk       (clk),
        .i_rst       (rst1),
        .i_clear     (clr1),
        .i_bit       (b1),
        .i_bit_valid (bv1),
        .o_bit_ready (br1),
        .o_word1     (w1_1),
        .o_word2     (w2_1),
        .o_valid     (v1),
        .i_ready     (rdy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit to the BITS=3 instance for one edge.
    task automatic send(input logic x);
        bv = 1'b1;
        b  = x;
        tick();
    endtask

    initial begin
        logic [5:0] seq;

        rst  = 1'b1; clr  = 1'b0; bv  = 1'b1; b  = 1'b1; rdy  = 1'b0;
        rst1 = 1'b1; clr1 = 1'b0; bv1 = 1'b0; b1 = 1'b0; rdy1 = 1'b0;

        // ---------------- reset ----------------
        repeat (3) tick();
        check("rst_ready", br, 1'b0);
        check("rst_valid", v, 1'b0);
        check("rst_word1", w1, 3'b000);
        check("rst_word2", w2, 3'b000);
        bv  = 1'b0;
        rst = 1'b0;
        #1;
        check("rel_ready", br, 1'b1);

        // ---------------- basic pair: 1,0,1 | 0,0,0 ----------------
        rdy = 1'b1;
        seq = 6'b000101;            // seq[i] is the i-th streamed bit
        for (int i = 0; i < 6; i++) begin
            send(seq[i]);
            if (i == 4) check("basic_valid_early", v, 1'b0);
        end
        check("basic_word1", w1, 3'b101);
        check("basic_word2", w2, 3'b000);
        check("basic_valid", v, 1'b1);
        check("basic_ready_hold", br, 1'b0);
        bv = 1'b0;
        tick();
        check("basic_valid_one_cycle", v, 1'b0);
        check("basic_ready_again", br, 1'b1);

        // ---------------- back-pressure: 0,1,1 | 1,0,1 ----------------
        rdy = 1'b0;
        seq = 6'b101110;
        for (int i = 0; i < 6; i++) send(seq[i]);
        check("bp_valid", v, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(i[0]);
            check("bp_ready_low", br, 1'b0);
            check("bp_valid_held", v, 1'b1);
        end
        check("bp_word1_stable", w1, 3'b110);
        check("bp_word2_stable", w2, 3'b101);
        bv = 1'b1; b = 1'b1; rdy = 1'b1;
        tick();
        check("bp_valid_fall", v, 1'b0);
        check("bp_ready_rise", br, 1'b1);
        check("bp_word1_not_yet", w1, 3'b110);
        tick();
        check("bp_held_bit_captured", w1, 3'b111);
        bv = 1'b0; rdy = 1'b0;

        // ---------------- clear mid-capture ----------------
        clr = 1'b1; tick(); clr = 1'b0;          // realign to word1[0]
        for (int i = 0; i < 4; i++) send(1'b0);  // word1=000, word2[0]=0
        check("clr_w2_partial", w2, 3'b100);
        clr = 1'b1; bv = 1'b1; b = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_bit_dropped", w2, 3'b100);
        check("clr_valid_low", v, 1'b0);
        check("clr_ready", br, 1'b1);
        seq = 6'b010111;
        for (int i = 0; i < 6; i++) begin
            send(seq[i]);
            if (i == 4) check("clr_valid_not_early", v, 1'b0);
        end
        check("clr_word1", w1, 3'b111);
        check("clr_word2", w2, 3'b010);
        check("clr_valid", v, 1'b1);

        // ---------------- clear vs handshake in HOLD ----------------
        bv = 1'b0; clr = 1'b1; rdy = 1'b1;
        tick();
        clr = 1'b0; rdy = 1'b0;
        check("cvh_valid", v, 1'b0);
        check("cvh_ready", br, 1'b1);
        check("cvh_word1_kept", w1, 3'b111);
        check("cvh_word2_kept", w2, 3'b010);
        for (int i = 0; i < 3; i++) send(1'b0);  // must land in word1
        check("cvh_fill1_word1", w1, 3'b000);
        check("cvh_fill1_word2", w2, 3'b010);
        send(1'b1);                              // word2[0] -> mid-FILL2
        check("cvh_fill2_word2", w2, 3'b011);
        bv = 1'b0;

        // ---------------- reset mid-FILL2 ----------------
        rst = 1'b1;
        tick();
        check("rst2_word1", w1, 3'b000);
        check("rst2_word2", w2, 3'b000);
        check("rst2_valid", v, 1'b0);
        check("rst2_ready", br, 1'b0);
        rst = 1'b0;
        #1;
        check("rst2_ready_rel", br, 1'b1);

        // ---------------- BITS=1 instance ----------------
        rst1 = 1'b0; rdy1 = 1'b1;
        #1;
        check("b1_ready", br1, 1'b1);
        bv1 = 1'b1; b1 = 1'b0;
        tick();
        check("b1_valid_after_1", v1, 1'b0);
        b1 = 1'b1;
        tick();
        check("b1_word1", w1_1, 1'b0);
        check("b1_word2", w2_1, 1'b1);
        check("b1_valid", v1, 1'b1);
        // Back-to-back with i_ready high: HOLD, FILL1, FILL2 -> one pair per
        // 3 cycles, so valid appears after every third edge.
        for (int k = 0; k < 9; k++) begin
            tick();
            check("b1_rate", v1, (k % 3 == 2) ? 1'b1 : 1'b0);
        end
        check("b1_word1_final", w1_1, 1'b1);
        check("b1_word2_final", w2_1, 1'b1);
        bv1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
